// File: rtl/mram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported MRAM array.
// One transaction at a time: IDLE -> ACCESS (WAIT_CYC cycles) -> DONE (1 cycle).
//
// Ports:
//   ck, reset                         clock, synchronous active-high reset
//   rN_req/we/addr/wdata (N=0,1)      requester N access (0 = xSPI slave, 1 = BIST)
//   rN_gnt                            one-cycle grant pulse (first ACCESS cycle)
//   rN_rvalid, rN_rdata               one-cycle completion pulse, read data
//   mem_cs/we/re/addr/wdata           array control and write path
//   mem_rdata                         array read data, valid on last ACCESS cycle
//   busy                              high whenever not IDLE
module mram_port_arbiter #(
  parameter int unsigned WAIT_CYC = 3,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              ck,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_q;      // id of the requester granted most recently
  logic              id_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              gnt0_q, gnt1_q, rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              cs_q, mwe_q, mre_q, busy_q;

  logic              win_id_d;
  logic              win_we_d;
  logic [ADDR_W-1:0] win_addr_d;
  logic [DATA_W-1:0] win_wdata_d;

  // Round-robin pick: a tie goes to the requester not granted last.
  always_comb begin
    win_id_d = 1'b0;
    if (r0_req && r1_req) begin
      win_id_d = ~last_q;
    end else if (r1_req) begin
      win_id_d = 1'b1;
    end
    win_we_d    = win_id_d ? r1_we    : r0_we;
    win_addr_d  = win_id_d ? r1_addr  : r0_addr;
    win_wdata_d = win_id_d ? r1_wdata : r0_wdata;
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge ck) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      cs_q      <= 1'b0;
      mwe_q     <= 1'b0;
      mre_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (r0_req || r1_req) begin
            state_q <= ACCESS;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
            id_q    <= win_id_d;
            last_q  <= win_id_d;
            we_q    <= win_we_d;
            addr_q  <= win_addr_d;
            wdata_q <= win_wdata_d;
            cs_q    <= 1'b1;
            mwe_q   <= win_we_d;
            mre_q   <= ~win_we_d;
            gnt0_q  <= ~win_id_d;
            gnt1_q  <= win_id_d;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q   <= DONE;
            cs_q      <= 1'b0;
            mwe_q     <= 1'b0;
            mre_q     <= 1'b0;
            rvalid0_q <= ~id_q;
            rvalid1_q <= id_q;
            // Writes leave the requester's read data untouched.
            if (!we_q) begin
              if (id_q) rdata1_q <= mem_rdata;
              else      rdata0_q <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cs_q    <= 1'b0;
          mwe_q   <= 1'b0;
          mre_q   <= 1'b0;
        end
      endcase
    end
  end

  assign r0_gnt    = gnt0_q;
  assign r1_gnt    = gnt1_q;
  assign r0_rvalid = rvalid0_q;
  assign r1_rvalid = rvalid1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign mem_cs    = cs_q;
  assign mem_we    = mwe_q;
  assign mem_re    = mre_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mram_port_arbiter.sv
// Bench for mram_port_arbiter: two instances (WAIT_CYC=3 and WAIT_CYC=1) driven by
// directed scenarios and random traffic, checked every cycle against a
// transaction-age reference model.
module tb_mram_port_arbiter;

  logic        ck;
  logic        reset;
  logic        r0_req   [2];
  logic        r0_we    [2];
  logic [31:0] r0_addr  [2];
  logic [15:0] r0_wdata [2];
  logic        r0_gnt   [2];
  logic        r0_rvalid[2];
  logic [15:0] r0_rdata [2];
  logic        r1_req   [2];
  logic        r1_we    [2];
  logic [31:0] r1_addr  [2];
  logic [15:0] r1_wdata [2];
  logic        r1_gnt   [2];
  logic        r1_rvalid[2];
  logic [15:0] r1_rdata [2];
  logic        mem_cs   [2];
  logic        mem_we   [2];
  logic        mem_re   [2];
  logic [31:0] mem_addr [2];
  logic [15:0] mem_wdata[2];
  logic [15:0] mem_rdata[2];
  logic        busy     [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: age = cycle index inside the current transaction (0 = idle).
  int          m_age  [2];
  bit          m_last [2];
  bit          m_id   [2];
  bit          m_we   [2];
  logic [31:0] m_addr [2];
  logic [15:0] m_wdata[2];
  logic [15:0] m_rd0  [2];
  logic [15:0] m_rd1  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mram_port_arbiter #(.WAIT_CYC(g == 0 ? 3 : 1), .ADDR_W(32), .DATA_W(16)) u_dut (
      .ck(ck), .reset(reset),
      .r0_req(r0_req[g]), .r0_we(r0_we[g]), .r0_addr(r0_addr[g]), .r0_wdata(r0_wdata[g]),
      .r0_gnt(r0_gnt[g]), .r0_rvalid(r0_rvalid[g]), .r0_rdata(r0_rdata[g]),
      .r1_req(r1_req[g]), .r1_we(r1_we[g]), .r1_addr(r1_addr[g]), .r1_wdata(r1_wdata[g]),
      .r1_gnt(r1_gnt[g]), .r1_rvalid(r1_rvalid[g]), .r1_rdata(r1_rdata[g]),
      .mem_cs(mem_cs[g]), .mem_we(mem_we[g]), .mem_re(mem_re[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g])
    );
  end

  initial ck = 1'b0;
  always #5 ck = ~ck;

  function automatic int wc(int d);
    return (d == 0) ? 3 : 1;
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(int d);
    int w;
    w = wc(d);
    if (reset) begin
      m_age[d] = 0; m_last[d] = 1'b1; m_id[d] = 1'b0; m_we[d] = 1'b0;
      m_addr[d] = '0; m_wdata[d] = '0; m_rd0[d] = '0; m_rd1[d] = '0;
    end else if (m_age[d] == 0) begin
      if (r0_req[d] || r1_req[d]) begin
        m_id[d]    = (r0_req[d] && r1_req[d]) ? ~m_last[d] : r1_req[d];
        m_last[d]  = m_id[d];
        m_we[d]    = m_id[d] ? r1_we[d]    : r0_we[d];
        m_addr[d]  = m_id[d] ? r1_addr[d]  : r0_addr[d];
        m_wdata[d] = m_id[d] ? r1_wdata[d] : r0_wdata[d];
        m_age[d]   = 1;
      end
    end else begin
      if (m_age[d] == w && !m_we[d]) begin
        if (m_id[d]) m_rd1[d] = mem_rdata[d];
        else         m_rd0[d] = mem_rdata[d];
      end
      m_age[d] = (m_age[d] == w + 1) ? 0 : m_age[d] + 1;
    end
  endtask

  task automatic model_cmp(int d);
    int  a;
    bit  cs;
    a  = m_age[d];
    cs = (a >= 1) && (a <= wc(d));
    check_eq($sformatf("d%0d_gnt0", d),   32'(r0_gnt[d]),    32'(a == 1 && !m_id[d]));
    check_eq($sformatf("d%0d_gnt1", d),   32'(r1_gnt[d]),    32'(a == 1 && m_id[d]));
    check_eq($sformatf("d%0d_rv0", d),    32'(r0_rvalid[d]), 32'(a == wc(d) + 1 && !m_id[d]));
    check_eq($sformatf("d%0d_rv1", d),    32'(r1_rvalid[d]), 32'(a == wc(d) + 1 && m_id[d]));
    check_eq($sformatf("d%0d_rd0", d),    32'(r0_rdata[d]),  32'(m_rd0[d]));
    check_eq($sformatf("d%0d_rd1", d),    32'(r1_rdata[d]),  32'(m_rd1[d]));
    check_eq($sformatf("d%0d_cs", d),     32'(mem_cs[d]),    32'(cs));
    check_eq($sformatf("d%0d_mwe", d),    32'(mem_we[d]),    32'(cs && m_we[d]));
    check_eq($sformatf("d%0d_mre", d),    32'(mem_re[d]),    32'(cs && !m_we[d]));
    check_eq($sformatf("d%0d_maddr", d),  mem_addr[d],       m_addr[d]);
    check_eq($sformatf("d%0d_mwdata", d), 32'(mem_wdata[d]), 32'(m_wdata[d]));
    check_eq($sformatf("d%0d_busy", d),   32'(busy[d]),      32'(a != 0));
    check_eq($sformatf("d%0d_one_gnt", d), 32'(r0_gnt[d] && r1_gnt[d]), 32'(0));
  endtask

  // One clock: model consumes the values sampled at the edge, outputs checked #1 later.
  task automatic step();
    @(posedge ck);
    for (int d = 0; d < 2; d++) model_edge(d);
    #1;
    for (int d = 0; d < 2; d++) model_cmp(d);
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      r0_req[d] = 1'b0; r0_we[d] = 1'b0; r0_addr[d] = '0; r0_wdata[d] = '0;
      r1_req[d] = 1'b0; r1_we[d] = 1'b0; r1_addr[d] = '0; r1_wdata[d] = '0;
      mem_rdata[d] = '0;
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (2) step();
    reset = 1'b0;

    // Reset state
    check_eq("rst_busy",  32'(busy[0]),     32'(0));
    check_eq("rst_cs",    32'(mem_cs[0]),   32'(0));
    check_eq("rst_addr",  mem_addr[1],      32'h0);
    check_eq("rst_rdata", 32'(r0_rdata[0]), 32'(0));

    // Single read on r0, WAIT_CYC=3
    r0_req[0] = 1'b1; r0_we[0] = 1'b0; r0_addr[0] = 32'h10; mem_rdata[0] = 16'hA55A;
    step();
    r0_req[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) step();
      check_eq($sformatf("rd_gnt_c%0d", i), 32'(r0_gnt[0]),    32'(i == 1));
      check_eq($sformatf("rd_re_c%0d", i),  32'(mem_re[0]),    32'(i <= 3));
      check_eq($sformatf("rd_rv_c%0d", i),  32'(r0_rvalid[0]), 32'(i == 4));
      if (i <= 3) check_eq($sformatf("rd_addr_c%0d", i), mem_addr[0], 32'h10);
      if (i == 4) check_eq("rd_data", 32'(r0_rdata[0]), 32'h0000A55A);
    end

    // Single write on r1
    r1_req[0] = 1'b1; r1_we[0] = 1'b1; r1_addr[0] = 32'h20; r1_wdata[0] = 16'h1234;
    mem_rdata[0] = 16'hBEEF;
    step();
    r1_req[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) step();
      check_eq($sformatf("wr_gnt_c%0d", i), 32'(r1_gnt[0]),    32'(i == 1));
      check_eq($sformatf("wr_we_c%0d", i),  32'(mem_we[0]),    32'(i <= 3));
      check_eq($sformatf("wr_rv_c%0d", i),  32'(r1_rvalid[0]), 32'(i == 4));
      check_eq($sformatf("wr_rd1_c%0d", i), 32'(r1_rdata[0]),  32'(0));
      if (i <= 3) begin
        check_eq($sformatf("wr_addr_c%0d", i),  mem_addr[0],       32'h20);
        check_eq($sformatf("wr_wdata_c%0d", i), 32'(mem_wdata[0]), 32'h1234);
      end
    end

    // Contention: both held, grants alternate every 5 cycles starting with r0
    r0_req[0] = 1'b1; r0_we[0] = 1'b0;
    r1_req[0] = 1'b1; r1_we[0] = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      check_eq($sformatf("rr_gnt0_c%0d", i), 32'(r0_gnt[0]), 32'(i == 1 || i == 11));
      check_eq($sformatf("rr_gnt1_c%0d", i), 32'(r1_gnt[0]), 32'(i == 6 || i == 16));
    end
    r0_req[0] = 1'b0; r1_req[0] = 1'b0;
    repeat (4) step();

    // Reset in the 2nd ACCESS cycle of an r0 read, then a tie must go to r0
    r0_req[0] = 1'b1; r0_addr[0] = 32'h44;
    step();
    r0_req[0] = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("abort_busy",  32'(busy[0]),      32'(0));
    check_eq("abort_cs",    32'(mem_cs[0]),    32'(0));
    check_eq("abort_re",    32'(mem_re[0]),    32'(0));
    check_eq("abort_addr",  mem_addr[0],       32'h0);
    check_eq("abort_rdata", 32'(r0_rdata[0]),  32'(0));
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq($sformatf("abort_rv_c%0d", i), 32'(r0_rvalid[0]), 32'(0));
    end
    r0_req[0] = 1'b1; r1_req[0] = 1'b1;
    step();
    check_eq("tie_after_rst_gnt0", 32'(r0_gnt[0]), 32'(1));
    check_eq("tie_after_rst_gnt1", 32'(r1_gnt[0]), 32'(0));
    r0_req[0] = 1'b0; r1_req[0] = 1'b0;
    repeat (4) step();

    // WAIT_CYC=1: back-to-back r0 reads at the top address, addr changed after grant
    r0_req[1] = 1'b1; r0_we[1] = 1'b0; r0_addr[1] = 32'hFFFF_FFFF; mem_rdata[1] = 16'h5A5A;
    for (int i = 1; i <= 9; i++) begin
      step();
      check_eq($sformatf("w1_gnt_c%0d", i),  32'(r0_gnt[1]),    32'(i % 3 == 1));
      check_eq($sformatf("w1_re_c%0d", i),   32'(mem_re[1]),    32'(i % 3 == 1));
      check_eq($sformatf("w1_rv_c%0d", i),   32'(r0_rvalid[1]), 32'(i % 3 == 2));
      check_eq($sformatf("w1_addr_c%0d", i), mem_addr[1],       32'hFFFF_FFFF);
      if (i % 3 == 1) r0_addr[1] = 32'h0;
      if (i % 3 == 0) r0_addr[1] = 32'hFFFF_FFFF;
    end
    r0_req[1] = 1'b0;
    repeat (3) step();

    // Random traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 2; d++) begin
        r0_req[d]    = ($urandom_range(0, 2) != 0);
        r1_req[d]    = ($urandom_range(0, 2) != 0);
        r0_we[d]     = 1'($urandom_range(0, 1));
        r1_we[d]     = 1'($urandom_range(0, 1));
        r0_addr[d]   = $urandom;
        r1_addr[d]   = $urandom;
        r0_wdata[d]  = 16'($urandom);
        r1_wdata[d]  = 16'($urandom);
        mem_rdata[d] = 16'($urandom);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
